// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite read path.
package sprite_pkg;

    localparam int SPR_W_DEF  = 20;
    localparam int SPR_H_DEF  = 20;
    localparam int SPR_PIXELS = SPR_W_DEF * SPR_H_DEF;

    typedef logic [18:0] addr_t;     // frameRAM word address
    typedef logic [4:0]  pal_idx_t;  // palette index
    typedef logic [9:0]  coord_t;    // screen coordinate

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation divider plus frame counter; outputs the RAM base address of the current frame.
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES  = 1,
    parameter int ANIM_DIV    = 8,
    parameter int FRAME_WORDS = SPR_PIXELS
) (
    input  logic  Clk,
    input  logic  Reset,
    input  logic  frame_start,
    input  logic  anim_en,
    output addr_t frame_base
);

    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(ANIM_DIV - 1);

    logic [FW-1:0] frame;
    logic [DW-1:0] div;

    // Step the divider once per frame_start; each divider wrap advances the frame.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            div   <= '0;
            frame <= '0;
        end else if (frame_start && anim_en) begin
            if (div == DIV_LAST) begin
                div   <= '0;
                frame <= (frame == FRAME_LAST) ? '0 : frame + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign frame_base = addr_t'(frame) * addr_t'(FRAME_WORDS);

endmodule

// File: rtl/sprite_reader.sv
// Maps the VGA pixel stream onto a sprite box, drives frameRAM, returns palette index
// three cycles after the pixel was presented.
module sprite_reader
    import sprite_pkg::*;
#(
    parameter int       SPR_W      = SPR_W_DEF,
    parameter int       SPR_H      = SPR_H_DEF,
    parameter int       NUM_FRAMES = 1,
    parameter int       ANIM_DIV   = 8,
    parameter pal_idx_t TRANSP_IDX = '0
) (
    input  logic     Clk,
    input  logic     Reset,
    input  logic     pix_en,
    input  logic     frame_start,
    input  coord_t   DrawX,
    input  coord_t   DrawY,
    input  coord_t   SpriteX,
    input  coord_t   SpriteY,
    input  logic     flip_h,
    input  logic     anim_en,
    output addr_t    read_address,
    input  pal_idx_t ram_data,
    output logic     pixel_valid,
    output logic     sprite_hit,
    output pal_idx_t pixel_index
);

    coord_t      ax, ay;
    logic        aflip;
    addr_t       frame_base;
    logic [10:0] col_d, row_d;
    logic        inbox;
    addr_t       colf, addr_next;
    logic [2:1]  vld_pipe, hit_pipe;
    logic        hit3;

    sprite_anim_ctr #(
        .NUM_FRAMES (NUM_FRAMES),
        .ANIM_DIV   (ANIM_DIV),
        .FRAME_WORDS(SPR_W * SPR_H)
    ) u_anim (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .anim_en    (anim_en),
        .frame_base (frame_base)
    );

    // 11-bit differences: bit 10 set means the pixel lies left of / above the sprite.
    assign col_d = {1'b0, DrawX} - {1'b0, ax};
    assign row_d = {1'b0, DrawY} - {1'b0, ay};
    assign inbox = !col_d[10] && !row_d[10]
                 && (col_d[9:0] < 10'(SPR_W)) && (row_d[9:0] < 10'(SPR_H));
    assign colf  = aflip ? addr_t'(SPR_W - 1) - addr_t'(col_d[9:0]) : addr_t'(col_d[9:0]);
    assign addr_next = frame_base + addr_t'(row_d[9:0]) * addr_t'(SPR_W) + colf;
    assign hit3  = hit_pipe[2] && (ram_data != TRANSP_IDX);

    // Shadow registers, address stage and the three-deep valid/hit pipeline.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ax           <= '0;
            ay           <= '0;
            aflip        <= 1'b0;
            read_address <= '0;
            vld_pipe     <= '0;
            hit_pipe     <= '0;
            pixel_valid  <= 1'b0;
            sprite_hit   <= 1'b0;
            pixel_index  <= TRANSP_IDX;
        end else begin
            // A pixel coinciding with frame_start still sees the old values (comb path above).
            if (frame_start) begin
                ax    <= SpriteX;
                ay    <= SpriteY;
                aflip <= flip_h;
            end
            // Outside the box the address holds, so it never wraps off the sprite.
            if (pix_en && inbox)
                read_address <= addr_next;
            vld_pipe    <= {vld_pipe[1], pix_en};
            hit_pipe    <= {hit_pipe[1], pix_en && inbox};
            pixel_valid <= vld_pipe[2];
            sprite_hit  <= hit3;
            pixel_index <= hit3 ? ram_data : TRANSP_IDX;
        end
    end

endmodule
